// File: rtl/gate_trigger_sequencer_pkg.sv
// Shared definitions for the lap-timer gate sequencer: FSM state encoding
// and the polarity of a broken IR beam.
package gate_trigger_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_HOLDOFF = 2'd3
    } seq_state_t;

    // Raw and debounced gate levels read 0 while the beam is interrupted.
    localparam logic GATE_BROKEN = 1'b0;

endpackage

// File: rtl/gate_trigger_sequencer_debouncer.sv
// One IR gate: 2-flop synchroniser followed by a consecutive-sample debouncer.
// break_evt pulses for one cycle when the accepted level falls to "broken".
module gate_debouncer
    import gate_trigger_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_MS = 5
) (
    input  logic clk_1khz,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic break_evt
);

    localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS + 1) : 1;

    logic          sync1_reg;
    logic          sync2_reg;
    logic [CW-1:0] cnt_reg;
    logic          level_reg;
    logic          break_reg;

    // Synchronise, then accept a new level only after DEBOUNCE_MS mismatching samples in a row.
    always_ff @(posedge clk_1khz) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            cnt_reg   <= '0;
            level_reg <= 1'b1;
            break_reg <= 1'b0;
        end else begin
            sync1_reg <= raw_n;
            sync2_reg <= sync1_reg;
            break_reg <= 1'b0;
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CW'(DEBOUNCE_MS - 1)) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                    break_reg <= (sync2_reg == GATE_BROKEN);
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level     = level_reg;
    assign break_evt = break_reg;

endmodule

// File: rtl/gate_trigger_sequencer.sv
// Lap-timer gate sequencer: debounces the start/finish beams and produces
// single-cycle start/stop pulses, with a forced stop after TIMEOUT_MS.
module gate_trigger_sequencer
    import gate_trigger_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_MS = 5,
    parameter int TIMEOUT_MS  = 2000,
    parameter int HOLDOFF_MS  = 200
) (
    input  logic       clk_1khz,
    input  logic       reset,
    input  logic       arm,
    input  logic       abort,
    input  logic       gate_start_n,
    input  logic       gate_stop_n,
    output logic       start,
    output logic       stop,
    output logic       timeout,
    output logic       arm_rejected,
    output logic [1:0] state
);

    localparam int RW = $clog2(TIMEOUT_MS + 1);
    localparam int HW = $clog2(HOLDOFF_MS + 1);

    // Index 0 = start line, index 1 = finish line.
    logic [1:0] gate_raw_n;
    logic [1:0] gate_level;
    logic [1:0] gate_break;
    logic       unused_stop_level;

    assign gate_raw_n        = {gate_stop_n, gate_start_n};
    assign unused_stop_level = gate_level[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_gate
            gate_debouncer #(
                .DEBOUNCE_MS(DEBOUNCE_MS)
            ) u_deb (
                .clk_1khz (clk_1khz),
                .reset    (reset),
                .raw_n    (gate_raw_n[gi]),
                .level    (gate_level[gi]),
                .break_evt(gate_break[gi])
            );
        end
    endgenerate

    seq_state_t    state_reg, state_next;
    logic [RW-1:0] run_cnt_reg, run_cnt_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic          start_reg, start_next;
    logic          stop_reg, stop_next;
    logic          timeout_reg, timeout_next;
    logic          rej_reg, rej_next;

    // State, counters and registered output pulses.
    always_ff @(posedge clk_1khz) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            run_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            start_reg    <= 1'b0;
            stop_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            rej_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            run_cnt_reg  <= run_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            start_reg    <= start_next;
            stop_reg     <= stop_next;
            timeout_reg  <= timeout_next;
            rej_reg      <= rej_next;
        end
    end

    // Next-state and pulse decode; abort overrides everything, a real stop beats timeout.
    always_comb begin
        state_next    = state_reg;
        start_next    = 1'b0;
        stop_next     = 1'b0;
        timeout_next  = 1'b0;
        rej_next      = 1'b0;
        run_cnt_next  = '0;
        hold_cnt_next = '0;

        // Counters only run in their own state, so they start from zero on entry.
        if (state_reg == ST_RUNNING) begin
            run_cnt_next = (run_cnt_reg == RW'(TIMEOUT_MS)) ? run_cnt_reg : run_cnt_reg + 1'b1;
        end
        if (state_reg == ST_HOLDOFF) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
        end

        if (abort) begin
            state_next = ST_IDLE;
            stop_next  = (state_reg == ST_RUNNING);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arm) begin
                        if (gate_level[0] == GATE_BROKEN) begin
                            rej_next = 1'b1;
                        end else begin
                            state_next = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (gate_break[0]) begin
                        start_next = 1'b1;
                        state_next = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (gate_break[1]) begin
                        stop_next  = 1'b1;
                        state_next = ST_HOLDOFF;
                    end else if (run_cnt_reg == RW'(TIMEOUT_MS - 1)) begin
                        stop_next    = 1'b1;
                        timeout_next = 1'b1;
                        state_next   = ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt_reg == HW'(HOLDOFF_MS - 1)) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign start        = start_reg;
    assign stop         = stop_reg;
    assign timeout      = timeout_reg;
    assign arm_rejected = rej_reg;
    assign state        = state_reg;

endmodule
